// File: rtl/vlsu_mem_sequencer_if.sv
// Bundle of the command, vector-register-file, scalar and data-memory signals
// around the vector load/store sequencer.
interface vlsu_mem_sequencer_if #(
    parameter int VLEN = 256,
    parameter int ELEN = 32
);
    logic            cmd_valid;
    logic            cmd_ready;
    logic            cmd_store;
    logic [4:0]      cmd_vreg;
    logic [31:0]     cmd_base;

    logic [4:0]      vrf_raddr;
    logic [VLEN-1:0] vrf_rdata;
    logic            vrf_we;
    logic [4:0]      vrf_waddr;
    logic [VLEN-1:0] vrf_wdata;

    logic            s_req;
    logic            s_we;
    logic [31:0]     s_addr;
    logic [ELEN-1:0] s_wdata;
    logic            s_gnt;
    logic            s_rvalid;
    logic [ELEN-1:0] s_rdata;

    logic            mem_en;
    logic            mem_we;
    logic [31:0]     mem_addr;
    logic [ELEN-1:0] mem_wdata;
    logic [ELEN-1:0] mem_rdata;

    logic            busy;
    logic            done;

    // The sequencer owns the memory port, so it is the master side.
    modport master (
        input  cmd_valid, cmd_store, cmd_vreg, cmd_base,
        output cmd_ready,
        output vrf_raddr, vrf_we, vrf_waddr, vrf_wdata,
        input  vrf_rdata,
        input  s_req, s_we, s_addr, s_wdata,
        output s_gnt, s_rvalid, s_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata,
        output busy, done
    );

    modport slave (
        output cmd_valid, cmd_store, cmd_vreg, cmd_base,
        input  cmd_ready,
        input  vrf_raddr, vrf_we, vrf_waddr, vrf_wdata,
        output vrf_rdata,
        output s_req, s_we, s_addr, s_wdata,
        input  s_gnt, s_rvalid, s_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata,
        input  busy, done
    );
endinterface

// File: rtl/vlsu_mem_sequencer.sv
// Splits one whole-register vle32/vse32 into eight word beats on the shared
// data-memory port; scalar accesses win the port whenever the sequencer is idle.
module vlsu_mem_sequencer #(
    parameter int VLEN  = 256,
    parameter int ELEN  = 32,
    parameter int NELEM = VLEN / ELEN
) (
    input  logic                  clk,
    input  logic                  reset,
    vlsu_mem_sequencer_if.master  bus
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LBEAT = 3'd1,
        LLAST = 3'd2,
        SSNAP = 3'd3,
        SBEAT = 3'd4,
        FIN   = 3'd5
    } state_e;

    state_e          state_q, state_d;
    logic            store_q, store_d;
    logic [4:0]      vreg_q, vreg_d;
    logic [31:0]     base_q, base_d;
    logic [2:0]      cnt_q, cnt_d;
    logic [VLEN-1:0] buf_q, buf_d;
    logic            s_rvalid_q, s_rvalid_d;

    logic [31:0]     beat_addr;
    logic [2:0]      prev_idx;
    logic            last_beat;

    // base_q is stored word-aligned, so the sum wraps naturally modulo 2^32.
    assign beat_addr = base_q + {27'd0, cnt_q, 2'b00};
    assign prev_idx  = cnt_q - 3'd1;
    assign last_beat = (cnt_q == 3'(NELEM - 1));

    assign bus.s_rvalid = s_rvalid_q;
    assign bus.s_rdata  = bus.mem_rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            store_q    <= 1'b0;
            vreg_q     <= '0;
            base_q     <= '0;
            cnt_q      <= '0;
            buf_q      <= '0;
            s_rvalid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            store_q    <= store_d;
            vreg_q     <= vreg_d;
            base_q     <= base_d;
            cnt_q      <= cnt_d;
            buf_q      <= buf_d;
            s_rvalid_q <= s_rvalid_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        store_d    = store_q;
        vreg_d     = vreg_q;
        base_d     = base_q;
        cnt_d      = cnt_q;
        buf_d      = buf_q;
        s_rvalid_d = 1'b0;

        bus.cmd_ready = 1'b0;
        bus.s_gnt     = 1'b0;
        bus.mem_en    = 1'b0;
        bus.mem_we    = 1'b0;
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.vrf_we    = 1'b0;
        bus.vrf_waddr = '0;
        bus.vrf_wdata = '0;
        bus.done      = 1'b0;
        bus.busy      = (state_q != IDLE);
        bus.vrf_raddr = (state_q != IDLE && store_q) ? vreg_q : bus.cmd_vreg;

        case (state_q)
            IDLE: begin
                bus.cmd_ready = !bus.s_req;
                bus.s_gnt     = bus.s_req;
                if (bus.s_req) begin
                    bus.mem_en    = 1'b1;
                    bus.mem_we    = bus.s_we;
                    bus.mem_addr  = bus.s_addr;
                    bus.mem_wdata = bus.s_wdata;
                    s_rvalid_d    = !bus.s_we;
                end else if (bus.cmd_valid) begin
                    store_d = bus.cmd_store;
                    vreg_d  = bus.cmd_vreg;
                    base_d  = {bus.cmd_base[31:2], 2'b00};
                    cnt_d   = '0;
                    state_d = bus.cmd_store ? SSNAP : LBEAT;
                end
            end
            LBEAT: begin
                bus.mem_en   = 1'b1;
                bus.mem_addr = beat_addr;
                // Read data lags its beat by one cycle, so beat i lands element i-1.
                if (cnt_q != 3'd0) begin
                    buf_d[prev_idx*ELEN +: ELEN] = bus.mem_rdata;
                end
                cnt_d = cnt_q + 3'd1;
                if (last_beat) begin
                    state_d = LLAST;
                end
            end
            LLAST: begin
                buf_d[(NELEM-1)*ELEN +: ELEN] = bus.mem_rdata;
                state_d = FIN;
            end
            SSNAP: begin
                buf_d   = bus.vrf_rdata;
                cnt_d   = '0;
                state_d = SBEAT;
            end
            SBEAT: begin
                bus.mem_en    = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_addr  = beat_addr;
                bus.mem_wdata = buf_q[cnt_q*ELEN +: ELEN];
                cnt_d = cnt_q + 3'd1;
                if (last_beat) begin
                    state_d = FIN;
                end
            end
            FIN: begin
                bus.done      = 1'b1;
                bus.vrf_we    = !store_q;
                bus.vrf_waddr = vreg_q;
                bus.vrf_wdata = store_q ? '0 : buf_q;
                state_d       = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_vlsu_mem_sequencer.sv
// Directed bench for vlsu_mem_sequencer: load, store, scalar contention,
// burst lock, reset mid-load and address wrap.
module tb_vlsu_mem_sequencer;

    localparam int VLEN = 256;
    localparam int ELEN = 32;

    localparam logic [255:0] LOADV = {32'h88888888, 32'h77777777, 32'h66666666, 32'h55555555,
                                      32'h44444444, 32'h33333333, 32'h22222222, 32'h11111111};
    localparam logic [255:0] WRAPV = {32'h00000105, 32'h00000104, 32'h00000103, 32'h00000102,
                                      32'h00000101, 32'h00000100, 32'hCAFE0001, 32'hCAFE0000};

    logic clk = 1'b0;
    logic reset;
    logic preload;
    always #5 clk = ~clk;

    vlsu_mem_sequencer_if #(.VLEN(VLEN), .ELEN(ELEN)) bus ();

    vlsu_mem_sequencer #(.VLEN(VLEN), .ELEN(ELEN), .NELEM(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [31:0]  mem [256];
    logic [31:0]  mem_rdata_q;
    logic [255:0] vrf [32];

    assign bus.mem_rdata = mem_rdata_q;
    assign bus.vrf_rdata = vrf[bus.vrf_raddr];

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 8; i++) begin
                mem[8 + i]          <= 32'h11111111 * (i + 1);
                mem[i]              <= 32'h100 + i;
                vrf[3][32*i +: 32]  <= 32'hA0 + i;
            end
            mem[254] <= 32'hCAFE0000;
            mem[255] <= 32'hCAFE0001;
        end else begin
            if (bus.mem_en) begin
                if (bus.mem_we) mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
                else            mem_rdata_q <= mem[bus.mem_addr[9:2]];
            end
            if (bus.vrf_we) vrf[bus.vrf_waddr] <= bus.vrf_wdata;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    logic [31:0] wrap_exp [8];

    initial begin
        wrap_exp = '{32'hFFFFFFF8, 32'hFFFFFFFC, 32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h14};
        reset = 1'b1;
        preload = 1'b1;
        bus.cmd_valid = 1'b0; bus.cmd_store = 1'b0; bus.cmd_vreg = 5'd7; bus.cmd_base = '0;
        bus.s_req = 1'b0; bus.s_we = 1'b0; bus.s_addr = '0; bus.s_wdata = '0;

        // reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_busy",      256'(bus.busy),      256'(0));
        chk("rst_cmd_ready", 256'(bus.cmd_ready), 256'(1));
        chk("rst_vrf_raddr", 256'(bus.vrf_raddr), 256'(7));
        chk("rst_mem_en",    256'(bus.mem_en),    256'(0));
        chk("rst_vrf_we",    256'(bus.vrf_we),    256'(0));
        chk("rst_done",      256'(bus.done),      256'(0));
        chk("rst_s_rvalid",  256'(bus.s_rvalid),  256'(0));
        chk("rst_s_gnt",     256'(bus.s_gnt),     256'(0));
        reset = 1'b0;
        preload = 1'b0;

        // load v2 from 0x20
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_store = 1'b0; bus.cmd_vreg = 5'd2; bus.cmd_base = 32'h20;
        #1 chk("ld_accept", 256'(bus.cmd_ready), 256'(1));
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.cmd_valid = 1'b0;
            #1;
            chk($sformatf("ld_en_%0d", i),   256'({bus.mem_en, bus.mem_we}), 256'(2'b10));
            chk($sformatf("ld_addr_%0d", i), 256'(bus.mem_addr), 256'(32'h20 + 4*i));
        end
        @(negedge clk); #1;
        chk("ld_t9_idle_port", 256'({bus.mem_en, bus.vrf_we, bus.done}), 256'(0));
        @(negedge clk); #1;
        chk("ld_t10_we_done", 256'({bus.vrf_we, bus.done}), 256'(2'b11));
        chk("ld_t10_waddr",   256'(bus.vrf_waddr), 256'(2));
        chk("ld_t10_wdata",   bus.vrf_wdata, LOADV);
        @(negedge clk); #1;
        chk("ld_t11_idle", 256'({bus.busy, bus.done, bus.vrf_we, bus.cmd_ready}), 256'(4'b0001));
        chk("ld_vrf_v2", vrf[2], LOADV);

        // store v3 to 0x80
        bus.cmd_valid = 1'b1; bus.cmd_store = 1'b1; bus.cmd_vreg = 5'd3; bus.cmd_base = 32'h80;
        #1 chk("st_accept", 256'(bus.cmd_ready), 256'(1));
        @(negedge clk);
        bus.cmd_valid = 1'b0; bus.cmd_vreg = 5'd0;
        #1;
        chk("st_snap_raddr", 256'(bus.vrf_raddr), 256'(3));
        chk("st_snap_port",  256'({bus.busy, bus.mem_en}), 256'(2'b10));
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); #1;
            chk($sformatf("st_en_%0d", i),    256'({bus.mem_en, bus.mem_we}), 256'(2'b11));
            chk($sformatf("st_addr_%0d", i),  256'(bus.mem_addr), 256'(32'h80 + 4*i));
            chk($sformatf("st_wdata_%0d", i), 256'(bus.mem_wdata), 256'(32'hA0 + i));
        end
        @(negedge clk); #1;
        chk("st_t10_done", 256'({bus.done, bus.vrf_we, bus.mem_en}), 256'(3'b100));
        @(negedge clk); #1;
        chk("st_t11_busy", 256'(bus.busy), 256'(0));
        chk("st_mem_first", 256'(mem[32]), 256'(32'hA0));
        chk("st_mem_last",  256'(mem[39]), 256'(32'hA7));

        // scalar read contends with a load to v4 for three cycles
        bus.s_req = 1'b1; bus.s_we = 1'b0; bus.s_addr = 32'h24;
        bus.cmd_valid = 1'b1; bus.cmd_store = 1'b0; bus.cmd_vreg = 5'd4; bus.cmd_base = 32'h20;
        for (int k = 0; k < 3; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            chk($sformatf("ct_gnt_%0d", k),  256'({bus.s_gnt, bus.cmd_ready}), 256'(2'b10));
            chk($sformatf("ct_port_%0d", k), 256'({bus.mem_en, bus.mem_we, bus.mem_addr}),
                256'({2'b10, 32'h24}));
            if (k > 0) begin
                chk($sformatf("ct_rvalid_%0d", k), 256'(bus.s_rvalid), 256'(1));
                chk($sformatf("ct_rdata_%0d", k),  256'(bus.s_rdata), 256'(32'h22222222));
            end
        end
        @(negedge clk);
        bus.s_req = 1'b0;
        #1;
        chk("ct_accept", 256'({bus.cmd_ready, bus.s_gnt}), 256'(2'b10));
        chk("ct_last_rvalid", 256'({bus.s_rvalid, bus.s_rdata}), 256'({1'b1, 32'h22222222}));
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        #1;
        chk("ct_t1_rvalid", 256'(bus.s_rvalid), 256'(0));
        chk("ct_t1_beat0",  256'({bus.mem_en, bus.mem_addr}), 256'({1'b1, 32'h20}));
        @(negedge clk); #1;
        chk("ct_t2_beat1", 256'(bus.mem_addr), 256'(32'h24));

        // scalar write held from T+3: locked out until the burst ends
        for (int c = 3; c <= 10; c++) begin
            @(negedge clk);
            if (c == 3) begin
                bus.s_req = 1'b1; bus.s_we = 1'b1; bus.s_addr = 32'h200; bus.s_wdata = 32'hDEADBEEF;
            end
            #1;
            chk($sformatf("lk_gnt_t%0d", c), 256'(bus.s_gnt), 256'(0));
            if (c >= 9) chk($sformatf("lk_no_en_t%0d", c), 256'(bus.mem_en), 256'(0));
            if (c == 10) begin
                chk("lk_t10_we",    256'({bus.vrf_we, bus.vrf_waddr}), 256'({1'b1, 5'd4}));
                chk("lk_t10_wdata", bus.vrf_wdata, LOADV);
            end
        end
        @(negedge clk); #1;
        chk("lk_t11_gnt", 256'({bus.s_gnt, bus.cmd_ready}), 256'(2'b10));
        chk("lk_t11_port", 256'({bus.mem_en, bus.mem_we, bus.mem_addr, bus.mem_wdata}),
            256'({2'b11, 32'h200, 32'hDEADBEEF}));
        bus.s_req = 1'b0; bus.s_we = 1'b0;

        // reset in the middle of a load to v5
        @(negedge clk);
        bus.cmd_valid = 1'b1; bus.cmd_store = 1'b0; bus.cmd_vreg = 5'd5; bus.cmd_base = 32'h20;
        #1 chk("rm_accept", 256'(bus.cmd_ready), 256'(1));
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            bus.cmd_valid = 1'b0;
            if (c == 5) reset = 1'b1;
            #1 chk($sformatf("rm_busy_t%0d", c), 256'(bus.busy), 256'(1));
        end
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rm_t6_idle", 256'({bus.busy, bus.mem_en, bus.cmd_ready}), 256'(3'b001));
        for (int c = 7; c <= 12; c++) begin
            @(negedge clk); #1;
            chk($sformatf("rm_quiet_t%0d", c), 256'({bus.vrf_we, bus.done}), 256'(0));
        end

        // unaligned base that wraps past 2^32, load to v6
        bus.cmd_valid = 1'b1; bus.cmd_vreg = 5'd6; bus.cmd_base = 32'hFFFFFFFB;
        #1 chk("wr_accept", 256'(bus.cmd_ready), 256'(1));
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.cmd_valid = 1'b0;
            #1 chk($sformatf("wr_addr_%0d", i), 256'(bus.mem_addr), 256'(wrap_exp[i]));
        end
        repeat (2) @(negedge clk);
        #1;
        chk("wr_t10_we",    256'({bus.vrf_we, bus.vrf_waddr, bus.done}), 256'({1'b1, 5'd6, 1'b1}));
        chk("wr_t10_wdata", bus.vrf_wdata, WRAPV);
        @(negedge clk); #1;
        chk("wr_t11_busy", 256'(bus.busy), 256'(0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vlsu_mem_sequencer.md
# vlsu_mem_sequencer

Sequencer and memory-port arbiter for the vector load/store path of the RISC-V vector core. It takes one whole-register `vle32`/`vse32` command from decode and breaks it into eight 32-bit data-memory beats: element i goes to or from address `base + 4*i`. Load beats are assembled into one 256-bit vector-register write; store data is one 256-bit vector-register snapshot. The block also shares the single data-memory port with the scalar load/store unit.

## Interface
Parameters:
- `VLEN`, 256: vector register width in bits.
- `ELEN`, 32: element and memory word width in bits.
- `NELEM`, VLEN/ELEN = 8: beats per command.

Ports:
- `clk`, input, 1: the single clock.
- `reset`, input, 1: one clock; reset is synchronous and active-high.
- `cmd_valid`, input, 1: a vector memory command is presented.
- `cmd_ready`, output, 1: the command is accepted when `cmd_valid && cmd_ready`.
- `cmd_store`, input, 1: 0 = `vle32`, 1 = `vse32`.
- `cmd_vreg`, input, 5: destination register (load) or source register (store).
- `cmd_base`, input, 32: base address, taken from the scalar register rs1.
- `vrf_raddr`, output, 5: vector register file read address. Read is combinational.
- `vrf_rdata`, input, 256: vector register file read data.
- `vrf_we`, output, 1: vector register file write enable, one-cycle pulse.
- `vrf_waddr`, output, 5: vector register file write address.
- `vrf_wdata`, output, 256: vector register file write data.
- `s_req`, input, 1: scalar access request.
- `s_we`, input, 1: scalar access is a write.
- `s_addr`, input, 32: scalar access address.
- `s_wdata`, input, 32: scalar write data.
- `s_gnt`, output, 1: scalar access is issued to memory this cycle.
- `s_rvalid`, output, 1: scalar read data is valid; asserted one cycle after a granted read.
- `s_rdata`, output, 32: scalar read data, equal to `mem_rdata`.
- `mem_en`, output, 1: data memory access strobe.
- `mem_we`, output, 1: data memory write strobe.
- `mem_addr`, output, 32: data memory address.
- `mem_wdata`, output, 32: data memory write data.
- `mem_rdata`, input, 32: data memory read data, registered. It is valid one cycle after `mem_en && !mem_we`.
- `busy`, output, 1: high in every state except IDLE.
- `done`, output, 1: one-cycle pulse when a command completes.

## Operation
- States are IDLE, LBEAT, LLAST, SSNAP, SBEAT and FIN.
- Transitions:
  - IDLE goes to LBEAT on an accepted load, or to SSNAP on an accepted store.
  - LBEAT goes to LLAST after beat 7.
  - LLAST goes to FIN.
  - SSNAP goes to SBEAT.
  - SBEAT goes to FIN after beat 7.
  - FIN goes to IDLE.
- On accept, the block latches `cmd_store`, `cmd_vreg` and `cmd_base`. A 3-bit beat counter is cleared to 0.
- Address rule:
  - `mem_addr = {base[31:2],2'b00} + 4*i`, computed modulo 2^32 so it wraps.
  - The low two bits of the base are ignored.
- Element i occupies bits `[32*i +: 32]` of the 256-bit vector.
- Load path:
  - In LBEAT, beat i drives `mem_en=1`, `mem_we=0` and the element-i address.
  - `mem_rdata` is captured into element i-1 in the cycle after beat i-1 is issued. In LLAST it is captured into element 7.
  - In FIN, `vrf_we=1` and `vrf_waddr` equals the latched register.
- Store path:
  - `vrf_raddr` equals the latched register. Outside a store it equals `cmd_vreg`.
  - In SSNAP, `vrf_rdata` is captured into a 256-bit buffer.
  - In SBEAT, beat i drives `mem_en=1`, `mem_we=1`, `mem_wdata` = buffer element i, and the element-i address.
- Arbitration:
  - `s_gnt = s_req && state==IDLE`. Scalar has priority in IDLE.
  - `cmd_ready = (state==IDLE) && !s_req`.
  - When `s_gnt` is high, the `mem_*` outputs carry the scalar access in the same cycle.
  - A vector command waits as long as `s_req` is held.
  - During a burst the port is locked and `s_gnt=0`.
- `done` is asserted in FIN. `busy` is low only in IDLE.
- Outputs with no access in progress: `mem_en`, `mem_we` and `vrf_we` are 0 in every cycle without an access.

## Timing
- Let T be the cycle in which the command is accepted.
- Load:
  - Beats are issued at T+1 through T+8.
  - Data is captured at T+2 through T+9.
  - `vrf_we` and `done` are asserted at T+10.
  - The earliest next accept is at T+11.
- Store:
  - The snapshot is taken at T+1.
  - Writes are issued at T+2 through T+9.
  - `done` is asserted at T+10.
  - The earliest next accept is at T+11.
- A scalar read granted at T-1 returns data at T. This does not collide with vector beat 0.
- Reset values:
  - State is IDLE, and the counter, buffers and `s_rvalid` are 0.
  - All outputs are 0 except `cmd_ready`, which is `!s_req`, and `vrf_raddr`, which is `cmd_vreg`.
- Reset mid-command:
  - The block is in IDLE in the next cycle, and `vrf_we` and `done` are never asserted.
  - Store beats already written stay in memory.
- The register file write issued in FIN lands before any later command's SSNAP, so a store after a load to the same register reads the new value.

## Test plan
- **Load.** Memory words 0x11111111 through 0x88888888 at addresses 0x20 through 0x3C. Issue a load to v2 with base 0x20.
  - `mem_addr` must step 0x20, 0x24, …, 0x3C over T+1 through T+8.
  - At T+10, `vrf_we=1`, `vrf_waddr=2` and `vrf_wdata=0x88888888_…_11111111`, with `done=1`.
- **Store.** v3 holds elements 0 through 7 = 0xA0 through 0xA7. Issue a store to base 0x80.
  - Writes must occur at T+2 through T+9, with addresses 0x80 through 0x9C and data 0xA0 through 0xA7.
  - `done` must pulse at T+10.
- **Contention in IDLE.** Assert `s_req` and `cmd_valid` together for 3 cycles.
  - `s_gnt` must be 1 and `cmd_ready` must be 0 for all 3 cycles.
  - The command must be accepted in the cycle `s_req` falls.
  - A scalar read must see `s_rvalid` one cycle after each grant.
- **Burst lock.** Raise `s_req` at T+3 of a load and hold it.
  - `s_gnt` must be 0 through T+10 and 1 at T+11.
  - No vector `mem_en` may appear after T+8.
- **Reset mid-load.** Assert `reset` at T+5.
  - `busy=0` next cycle, no `vrf_we`, and a new command is accepted cleanly.
- **Wrap and alignment.** Issue a command with base 0xFFFFFFFB.
  - Addresses must be 0xFFFFFFF8, 0xFFFFFFFC, 0x0, 0x4, …, 0x14.
